// File: rtl/vscale_dmem_bridge.sv
// Bridges the vscale two-phase dmem port onto a word-wide valid/ready memory bus.
// One bus transaction per accepted address phase; faults and timeouts reported on dmem_badmem_e.
module vscale_dmem_bridge #(
  parameter logic [31:0] MEM_BYTES = 32'h0001_0000,
  parameter logic [7:0]  TIMEOUT   = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_en,
  input  logic        dmem_wen,
  input  logic [2:0]  dmem_size,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata_delayed,
  output logic [31:0] dmem_rdata,
  output logic        dmem_wait,
  output logic        dmem_badmem_e,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_req_wen,
  output logic [31:0] bus_req_addr,
  output logic [3:0]  bus_req_wstrb,
  output logic [31:0] bus_req_wdata,
  input  logic        bus_resp_valid,
  input  logic [31:0] bus_resp_rdata,
  input  logic        bus_resp_err
);

  typedef enum logic [1:0] {S_IDLE, S_BAD, S_REQ, S_RESP} state_t;

  state_t      state_q;
  logic [31:0] addr_q;
  logic        wen_q;
  logic [1:0]  size_q;
  logic [7:0]  cnt_q;

  logic unused_size;
  assign unused_size = dmem_size[2];

  logic timeout_hit, resp_done, accept, in_req, in_resp, new_bad;
  logic [3:0] wstrb;

  assign in_req      = (state_q == S_REQ);
  assign in_resp     = (state_q == S_RESP);
  assign timeout_hit = (TIMEOUT != 8'd0) && (cnt_q == TIMEOUT);
  assign resp_done   = in_resp && (bus_resp_valid || timeout_hit);
  assign dmem_wait   = in_req || (in_resp && !resp_done);
  assign accept      = dmem_en && !dmem_wait;

  // Fault check on the values being captured this cycle, so the next state is already known.
  assign new_bad = (dmem_size[1:0] == 2'd3)
                || ((dmem_size[1:0] == 2'd1) && dmem_addr[0])
                || ((dmem_size[1:0] == 2'd2) && (|dmem_addr[1:0]))
                || (dmem_addr >= MEM_BYTES);

  always_comb begin
    wstrb = 4'b1111;
    case (size_q)
      2'd0:    wstrb = 4'b0001 << addr_q[1:0];
      2'd1:    wstrb = 4'b0011 << addr_q[1:0];
      default: wstrb = 4'b1111;
    endcase
  end

  assign bus_req_valid = in_req;
  assign bus_req_wen   = in_req & wen_q;
  assign bus_req_addr  = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign bus_req_wstrb = in_req ? wstrb : 4'd0;
  assign bus_req_wdata = in_req ? dmem_wdata_delayed : 32'd0;

  // A response takes priority over a coincident timeout.
  assign dmem_rdata    = (in_resp && bus_resp_valid) ? bus_resp_rdata : 32'd0;
  assign dmem_badmem_e = (state_q == S_BAD)
                      || (in_resp && bus_resp_valid && bus_resp_err)
                      || (in_resp && !bus_resp_valid && timeout_hit);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= 32'd0;
      wen_q   <= 1'b0;
      size_q  <= 2'd0;
      cnt_q   <= 8'd0;
    end else begin
      if (accept) begin
        addr_q <= dmem_addr;
        wen_q  <= dmem_wen;
        size_q <= dmem_size[1:0];
      end
      case (state_q)
        S_REQ: begin
          if (bus_req_ready) begin
            state_q <= S_RESP;
            cnt_q   <= 8'd0;
          end
        end
        S_RESP: begin
          if (resp_done) begin
            state_q <= accept ? (new_bad ? S_BAD : S_REQ) : S_IDLE;
          end else if (cnt_q != 8'hff) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          state_q <= accept ? (new_bad ? S_BAD : S_REQ) : S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vscale_dmem_bridge.sv
// Directed bench for vscale_dmem_bridge: hand-computed expectations per cycle.
module tb_vscale_dmem_bridge;
  logic        clk = 1'b0;
  logic        reset;
  logic        dmem_en, dmem_wen;
  logic [2:0]  dmem_size;
  logic [31:0] dmem_addr, dmem_wdata_delayed;
  logic [31:0] dmem_rdata;
  logic        dmem_wait, dmem_badmem_e;
  logic        bus_req_valid, bus_req_ready, bus_req_wen;
  logic [31:0] bus_req_addr, bus_req_wdata;
  logic [3:0]  bus_req_wstrb;
  logic        bus_resp_valid, bus_resp_err;
  logic [31:0] bus_resp_rdata;

  int total = 0;
  int bad   = 0;
  int hs_cnt = 0;

  always #5 clk = ~clk;

  vscale_dmem_bridge #(.MEM_BYTES(32'h0001_0000), .TIMEOUT(8'd4)) dut (
    .clk(clk), .reset(reset),
    .dmem_en(dmem_en), .dmem_wen(dmem_wen), .dmem_size(dmem_size),
    .dmem_addr(dmem_addr), .dmem_wdata_delayed(dmem_wdata_delayed),
    .dmem_rdata(dmem_rdata), .dmem_wait(dmem_wait), .dmem_badmem_e(dmem_badmem_e),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_req_wen(bus_req_wen), .bus_req_addr(bus_req_addr),
    .bus_req_wstrb(bus_req_wstrb), .bus_req_wdata(bus_req_wdata),
    .bus_resp_valid(bus_resp_valid), .bus_resp_rdata(bus_resp_rdata),
    .bus_resp_err(bus_resp_err)
  );

  always @(posedge clk) if (!reset && bus_req_valid && bus_req_ready) hs_cnt <= hs_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    dmem_en = 0; dmem_wen = 0; dmem_size = 3'd0; dmem_addr = 32'd0;
    bus_req_ready = 0; bus_resp_valid = 0; bus_resp_err = 0; bus_resp_rdata = 32'd0;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic [2:0] sz, input logic w);
    dmem_en = 1; dmem_addr = a; dmem_size = sz; dmem_wen = w;
  endtask

  logic [31:0] bad_addr [4] = '{32'h101, 32'h102, 32'h1_0000, 32'h0};
  logic [2:0]  bad_size [4] = '{3'd1, 3'd2, 3'd2, 3'd3};

  initial begin
    idle_in();
    dmem_wdata_delayed = 32'd0;
    reset = 1;
    step(); step();
    #1;
    chk("rst_wait", {31'd0, dmem_wait}, 0);
    chk("rst_bad", {31'd0, dmem_badmem_e}, 0);
    chk("rst_vld", {31'd0, bus_req_valid}, 0);
    chk("rst_strb", {28'd0, bus_req_wstrb}, 0);
    chk("rst_rdata", dmem_rdata, 0);
    reset = 0;

    // Load word, minimum latency
    step(); addr_phase(32'h100, 3'd2, 0); #1;
    chk("lw_n_wait", {31'd0, dmem_wait}, 0);
    step(); idle_in(); bus_req_ready = 1; #1;
    chk("lw_vld", {31'd0, bus_req_valid}, 1);
    chk("lw_wait", {31'd0, dmem_wait}, 1);
    chk("lw_addr", bus_req_addr, 32'h100);
    chk("lw_strb", {28'd0, bus_req_wstrb}, 32'hf);
    chk("lw_wen", {31'd0, bus_req_wen}, 0);
    step(); idle_in(); bus_resp_valid = 1; bus_resp_rdata = 32'hDEADBEEF; #1;
    chk("lw_done_wait", {31'd0, dmem_wait}, 0);
    chk("lw_rdata", dmem_rdata, 32'hDEADBEEF);
    chk("lw_bad", {31'd0, dmem_badmem_e}, 0);

    // Store byte with ready delayed 3 cycles
    step(); idle_in(); addr_phase(32'h203, 3'd0, 1); dmem_wdata_delayed = 32'h5A5A5A5A; #1;
    for (int i = 0; i < 4; i++) begin
      step(); idle_in(); bus_req_ready = (i == 3); #1;
      chk("sb_vld", {31'd0, bus_req_valid}, 1);
      chk("sb_addr", bus_req_addr, 32'h200);
      chk("sb_strb", {28'd0, bus_req_wstrb}, 32'h8);
      chk("sb_wen", {31'd0, bus_req_wen}, 1);
      chk("sb_wdata", bus_req_wdata, 32'h5A5A5A5A);
      chk("sb_wait", {31'd0, dmem_wait}, 1);
    end
    step(); idle_in(); #1;
    chk("sb_resp_wait", {31'd0, dmem_wait}, 1);
    chk("sb_resp_vld", {31'd0, bus_req_valid}, 0);
    step(); idle_in(); bus_resp_valid = 1; #1;
    chk("sb_done_wait", {31'd0, dmem_wait}, 0);
    chk("sb_done_bad", {31'd0, dmem_badmem_e}, 0);

    // Faulting accesses: one-cycle badmem, no bus activity
    for (int k = 0; k < 4; k++) begin
      step(); idle_in(); addr_phase(bad_addr[k], bad_size[k], 0); #1;
      step(); idle_in(); #1;
      chk("mis_bad", {31'd0, dmem_badmem_e}, 1);
      chk("mis_wait", {31'd0, dmem_wait}, 0);
      chk("mis_vld", {31'd0, bus_req_valid}, 0);
      step(); #1;
      chk("mis_bad_clr", {31'd0, dmem_badmem_e}, 0);
    end

    // Bus error on response
    step(); idle_in(); addr_phase(32'h10, 3'd2, 0); #1;
    step(); idle_in(); bus_req_ready = 1; #1;
    step(); idle_in(); bus_resp_valid = 1; bus_resp_err = 1; #1;
    chk("err_bad", {31'd0, dmem_badmem_e}, 1);
    chk("err_wait", {31'd0, dmem_wait}, 0);

    // Timeout with TIMEOUT=4: four waiting RESP cycles, released on the fifth
    step(); idle_in(); addr_phase(32'h20, 3'd2, 0); #1;
    step(); idle_in(); bus_req_ready = 1; #1;
    for (int i = 0; i < 4; i++) begin
      step(); idle_in(); #1;
      chk("to_wait", {31'd0, dmem_wait}, 1);
      chk("to_nobad", {31'd0, dmem_badmem_e}, 0);
    end
    step(); idle_in(); #1;
    chk("to_rel_wait", {31'd0, dmem_wait}, 0);
    chk("to_rel_bad", {31'd0, dmem_badmem_e}, 1);
    chk("to_rel_rdata", dmem_rdata, 0);
    step(); idle_in(); bus_resp_valid = 1; bus_resp_rdata = 32'hBADBAD00; #1;
    chk("late_rdata", dmem_rdata, 0);
    chk("late_bad", {31'd0, dmem_badmem_e}, 0);

    // Back-to-back load / store / load
    step(); idle_in(); addr_phase(32'h30, 3'd2, 0); #1;
    step(); idle_in(); bus_req_ready = 1; #1;
    chk("b2b_a_addr", bus_req_addr, 32'h30);
    step(); idle_in(); bus_resp_valid = 1; bus_resp_rdata = 32'hAAAA0001;
    addr_phase(32'h34, 3'd2, 1); dmem_wdata_delayed = 32'h11223344; #1;
    chk("b2b_a_wait", {31'd0, dmem_wait}, 0);
    chk("b2b_a_rdata", dmem_rdata, 32'hAAAA0001);
    step(); idle_in(); bus_req_ready = 1; #1;
    chk("b2b_b_addr", bus_req_addr, 32'h34);
    chk("b2b_b_wen", {31'd0, bus_req_wen}, 1);
    chk("b2b_b_wdata", bus_req_wdata, 32'h11223344);
    step(); idle_in(); bus_resp_valid = 1; addr_phase(32'h38, 3'd2, 0); #1;
    chk("b2b_b_wait", {31'd0, dmem_wait}, 0);
    step(); idle_in(); bus_req_ready = 1; #1;
    chk("b2b_c_addr", bus_req_addr, 32'h38);
    chk("b2b_c_wen", {31'd0, bus_req_wen}, 0);
    step(); idle_in(); bus_resp_valid = 1; bus_resp_rdata = 32'h00000077; #1;
    chk("b2b_c_rdata", dmem_rdata, 32'h77);
    step(); idle_in(); #1;
    chk("b2b_idle_vld", {31'd0, bus_req_valid}, 0);

    // Reset while in RESP
    step(); idle_in(); addr_phase(32'h40, 3'd2, 0); #1;
    step(); idle_in(); bus_req_ready = 1; #1;
    step(); idle_in(); reset = 1; #1;
    chk("rr_pre_wait", {31'd0, dmem_wait}, 1);
    step(); #1;
    chk("rr_wait", {31'd0, dmem_wait}, 0);
    chk("rr_vld", {31'd0, bus_req_valid}, 0);
    chk("rr_bad", {31'd0, dmem_badmem_e}, 0);
    chk("rr_strb", {28'd0, bus_req_wstrb}, 0);
    chk("rr_addr", bus_req_addr, 0);
    reset = 0;
    step(); idle_in(); bus_resp_valid = 1; bus_resp_rdata = 32'h12345678; #1;
    chk("rr_idle_rdata", dmem_rdata, 0);
    chk("rr_idle_wait", {31'd0, dmem_wait}, 0);
    step(); idle_in(); #1;

    chk("handshakes", hs_cnt, 8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule

// File: doc/vscale_dmem_bridge.md
# vscale_dmem_bridge

Data-memory bridge between the vscale pipeline's two-phase dmem port and a word-wide valid/ready memory bus. It sits directly downstream of the pipeline's DX/WB stages:
- It accepts the address phase (`dmem_en`/`dmem_addr`/`dmem_size`/`dmem_wen`) in DX.
- It issues one bus transaction in the following WB data phase.
- It stalls the pipeline with `dmem_wait` until the bus responds.
- It flags misaligned, out-of-range, error and timed-out accesses on `dmem_badmem_e`.

## Interface

Parameters:
- `MEM_BYTES`, default `32'h0001_0000`: byte size of the addressable region. Addresses `>= MEM_BYTES` are bad.
- `TIMEOUT`, default 255: maximum cycles spent in RESP before the access is declared bad. Width is 8 bits; 0 disables the timeout.

Ports (clock and reset first):
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `dmem_en`  in  1  address-phase request from the pipeline.
- `dmem_wen`  in  1  1 = store, 0 = load.
- `dmem_size`  in  3  `MEM_TYPE` encoding. Bits [1:0]: 0 = byte, 1 = half, 2 = word, 3 = dword (dword is always bad).
- `dmem_addr`  in  32  byte address, address phase.
- `dmem_wdata_delayed`  in  32  lane-replicated store data, valid during the data phase.
- `dmem_rdata`  out  32  load data, data phase.
- `dmem_wait`  out  1  data phase not complete; the pipeline stalls.
- `dmem_badmem_e`  out  1  access fault, data phase.
- `bus_req_valid`  out  1  bus request valid.
- `bus_req_ready`  in  1  bus accepts the request.
- `bus_req_wen`  out  1  write request.
- `bus_req_addr`  out  32  word-aligned address, `{addr[31:2],2'b00}`.
- `bus_req_wstrb`  out  4  byte strobes.
- `bus_req_wdata`  out  32  write data.
- `bus_resp_valid`  in  1  response valid. Never asserted in the same cycle as the accepting handshake.
- `bus_resp_rdata`  in  32  read data.
- `bus_resp_err`  in  1  bus error, qualified by `bus_resp_valid`.

## Operation

Address phase:
- A request is accepted in a cycle with `dmem_en=1 && dmem_wait=0`.
- On acceptance, `addr`, `wen` and `size` are registered. The next cycle is the data phase.

Bad check, on the registered values:
- Bad if `size[1:0]==3`, half with `addr[0]`, word with `|addr[1:0]`, or `addr >= MEM_BYTES`.

Strobes:
- byte: `4'b0001<<addr[1:0]`
- half: `4'b0011<<addr[1:0]`
- word: `4'b1111`

Data path:
- `bus_req_wdata = dmem_wdata_delayed`, passed through. The pipeline holds it stable while stalled.
- `dmem_rdata = bus_resp_rdata`, passed through. Otherwise `dmem_rdata` is 0. The pipeline performs lane extraction.

FSM states: IDLE, BAD, REQ, RESP.
- **Acceptance:** from any state where `dmem_wait=0` (IDLE, BAD, or the final RESP cycle), acceptance goes to BAD if the registered access is bad, else REQ. Without acceptance the FSM goes to IDLE.
- **BAD:** one cycle. `dmem_badmem_e=1`, `dmem_wait=0`, no bus activity.
- **REQ:** `bus_req_valid=1`, `dmem_wait=1`. Request fields come from the registers. Stay in REQ until `bus_req_ready`, then go to RESP and clear the timeout counter.
- **RESP:** `dmem_wait=1`; the counter increments each cycle, saturating.
  - On `bus_resp_valid`: `dmem_wait=0`, and `dmem_badmem_e=bus_resp_err`.
  - On counter `== TIMEOUT` (TIMEOUT≠0) without a response: `dmem_wait=0`, `dmem_badmem_e=1`, `dmem_rdata=0`. A late response after a timeout is ignored while in IDLE/BAD and must not be attributed to a later transaction; the bus is required to drop timed-out requests.
  - Either completion is the final RESP cycle, which may accept a new address phase (back-to-back).
- **Load vs store:** stores complete exactly like loads (write response required), and `dmem_rdata` is don't-care for stores.
- **Outside the data phase:** `dmem_en=0` creates no transaction; `dmem_wen`/`dmem_size`/`dmem_addr` are ignored when not accepted.

## Timing

- **Reset:** state IDLE, counter 0, registered fields 0. All outputs are 0, including `dmem_wait`, `dmem_badmem_e`, `bus_req_valid` and `bus_req_wstrb`.
- **Reset mid-transaction:** abandons it. The bus shares `reset` and discards outstanding work.
- **Minimum load latency:** address phase at cycle N, REQ at N+1 with ready, response at N+2. `dmem_wait` is high in N+1 only and load data is presented in N+2.
- **`bus_req_valid`:** once asserted, it stays high with stable fields until `bus_req_ready`.
- **Bad access:** zero wait cycles.
- **Response and address phase in the same cycle:** when `bus_resp_valid` and a new address phase coincide, both are honoured.

## Test plan

- **Load word:** addr `0x100`, size 2, bus ready immediately, response 1 cycle later with `0xDEADBEEF` -> `dmem_wait` high 1 cycle, `dmem_rdata=0xDEADBEEF`, `bus_req_addr=0x100`, `wstrb=4'b1111`.
- **Store byte:** addr `0x203`, data `0x5A5A5A5A`, ready delayed 3 cycles -> `bus_req_valid` held 4 cycles with stable fields, `wstrb=4'b1000`, `wen=1`; `dmem_wait` deasserts on the response.
- **Misaligned accesses:** half at `0x101`, word at `0x102`, and addr `0x10000` -> each gives one-cycle `dmem_badmem_e=1`, `dmem_wait=0`, no `bus_req_valid`.
- **Bus error:** `bus_resp_err=1` on the response -> `dmem_badmem_e=1` in the completing cycle.
- **Timeout:** TIMEOUT=4, no response -> `dmem_wait` released with `dmem_badmem_e=1` after 4 RESP cycles.
- **Back-to-back and reset:** back-to-back load/store/load with a new address phase in each completion cycle -> no lost or duplicated requests. Then reset asserted in RESP -> all outputs 0 the next cycle and state IDLE.
